// File: rtl/grid_store.sv
// Flat cell-data store: single-cell writes (1-cycle latency) plus a one-cell-per-cycle fill sweep.
// wr_ready drops during a fill and in the cycle fill_start is raised; a refused write must be held.
module grid_store #(
  parameter int SIZE_X    = 10,
  parameter int SIZE_Y    = 10,
  parameter int CELL_BITS = 1,
  parameter int XBITS     = $clog2(SIZE_X),
  parameter int YBITS     = $clog2(SIZE_Y),
  parameter int GDBITS    = CELL_BITS*SIZE_X*SIZE_Y
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [XBITS-1:0]     wr_x,
  input  logic [YBITS-1:0]     wr_y,
  input  logic [CELL_BITS-1:0] wr_type,
  input  logic                 fill_start,
  input  logic [CELL_BITS-1:0] fill_type,
  output logic                 busy,
  output logic                 fill_done,
  output logic                 wr_err,
  output logic [GDBITS-1:0]    data
);

  localparam int NCELLS = SIZE_X*SIZE_Y;
  localparam int CBITS  = (NCELLS > 1) ? $clog2(NCELLS) : 1;

  typedef enum logic {IDLE, FILL} state_t;

  state_t               state_q, state_d;
  logic [CBITS-1:0]     cnt_q, cnt_d;
  logic [CELL_BITS-1:0] ftype_q, ftype_d;
  logic [GDBITS-1:0]    data_q, data_d;
  logic                 busy_q, busy_d;
  logic                 fill_done_q, fill_done_d;
  logic                 wr_err_q, wr_err_d;

  int  wr_idx;
  int  fill_idx;
  logic wr_in_range;

  assign wr_ready  = ~rst & (state_q == IDLE) & ~fill_start;
  assign busy      = busy_q;
  assign fill_done = fill_done_q;
  assign wr_err    = wr_err_q;
  assign data      = data_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ftype_d     = ftype_q;
    data_d      = data_q;
    busy_d      = busy_q;
    fill_done_d = 1'b0;
    wr_err_d    = 1'b0;
    wr_in_range = (int'(wr_x) < SIZE_X) && (int'(wr_y) < SIZE_Y);
    wr_idx      = int'(wr_y) * SIZE_X + int'(wr_x);
    fill_idx    = int'(cnt_q);

    case (state_q)
      IDLE: begin
        if (fill_start) begin
          state_d = FILL;
          cnt_d   = '0;
          ftype_d = fill_type;
          busy_d  = 1'b1;
        end else if (wr_valid && wr_ready) begin
          if (wr_in_range) data_d[wr_idx*CELL_BITS +: CELL_BITS] = wr_type;
          else             wr_err_d = 1'b1;
        end
      end
      FILL: begin
        // Sweep writes the current cell unconditionally; the last cell also closes the fill.
        data_d[fill_idx*CELL_BITS +: CELL_BITS] = ftype_q;
        if (cnt_q == CBITS'(NCELLS-1)) begin
          state_d     = IDLE;
          busy_d      = 1'b0;
          fill_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CBITS'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ftype_q     <= '0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      fill_done_q <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ftype_q     <= ftype_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      fill_done_q <= fill_done_d;
      wr_err_q    <= wr_err_d;
    end
  end

endmodule

// File: tb/tb_grid_store.sv
// Bench for grid_store: cell-array model checked every cycle plus directed literal checks.
module tb_grid_store;
  localparam int SX = 10;
  localparam int SY = 10;
  localparam int N  = SX*SY;

  logic clk = 1'b0;
  logic rst;
  logic wr_valid, wr_ready, fill_start, busy, fill_done, wr_err;
  logic [3:0] wr_x, wr_y;
  logic [0:0] wr_type, fill_type;
  logic [N-1:0] data;

  logic w2_valid, w2_ready, f2_start, busy2, done2, err2;
  logic [1:0] w2_x, w2_y, w2_type, f2_type;
  logic [23:0] data2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  grid_store dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_type(wr_type), .fill_start(fill_start),
    .fill_type(fill_type), .busy(busy), .fill_done(fill_done), .wr_err(wr_err),
    .data(data)
  );

  grid_store #(.SIZE_X(4), .SIZE_Y(3), .CELL_BITS(2)) dut2 (
    .clk(clk), .rst(rst), .wr_valid(w2_valid), .wr_ready(w2_ready),
    .wr_x(w2_x), .wr_y(w2_y), .wr_type(w2_type), .fill_start(f2_start),
    .fill_type(f2_type), .busy(busy2), .fill_done(done2), .wr_err(err2),
    .data(data2)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a cell array, a count of cells the fill still has to sweep, and pulse flags.
  int   m_cells [N];
  int   m_left, m_pos, m_ftype;
  logic m_err, m_done;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) m_cells[i] = 0;
      m_left = 0; m_pos = 0; m_ftype = 0; m_err = 0; m_done = 0;
    end else begin
      m_err = 0; m_done = 0;
      if (m_left > 0) begin
        m_cells[m_pos] = m_ftype;
        m_pos++;
        m_left--;
        if (m_left == 0) m_done = 1;
      end else if (fill_start) begin
        m_left = N; m_pos = 0; m_ftype = int'(fill_type);
      end else if (wr_valid) begin
        if (int'(wr_x) < SX && int'(wr_y) < SY) m_cells[int'(wr_y)*SX + int'(wr_x)] = int'(wr_type);
        else m_err = 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [N-1:0] mv;
    for (int i = 0; i < N; i++) mv[i] = m_cells[i][0];
    chk("model_data", 128'(data), 128'(mv));
    chk("model_busy", 128'(busy), 128'(m_left > 0));
    chk("model_fill_done", 128'(fill_done), 128'(m_done));
    chk("model_wr_err", 128'(wr_err), 128'(m_err));
    chk("model_wr_ready", 128'(wr_ready), 128'(!rst && m_left == 0 && !fill_start));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n, done_n, rdy_hi, wait_n;
    rst = 1'b1;
    wr_valid = 0; wr_x = 0; wr_y = 0; wr_type = 0; fill_start = 0; fill_type = 0;
    w2_valid = 0; w2_x = 0; w2_y = 0; w2_type = 0; f2_start = 0; f2_type = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("reset_data", 128'(data), 128'(0));
    chk("reset_busy", 128'(busy), 128'(0));
    chk("reset_ready", 128'(wr_ready), 128'(1));
    chk("reset_data2", 128'(data2), 128'(0));

    // 1: write (3,2,1) -> bit 23
    tick();
    wr_x = 3; wr_y = 2; wr_type = 1; wr_valid = 1;
    tick();
    wr_valid = 0;
    @(negedge clk);
    chk("t1_bit23", 128'(data[23]), 128'(1));
    chk("t1_others", 128'(data ^ (100'b1 << 23)), 128'(0));
    chk("t1_err", 128'(wr_err), 128'(0));

    // 2: out-of-range write (10,0,1)
    tick();
    wr_x = 10; wr_y = 0; wr_type = 1; wr_valid = 1;
    tick();
    wr_valid = 0;
    @(negedge clk);
    chk("t2_err_pulse", 128'(wr_err), 128'(1));
    chk("t2_data", 128'(data), 128'(100'b1 << 23));
    chk("t2_ready", 128'(wr_ready), 128'(1));
    tick();
    @(negedge clk);
    chk("t2_err_cleared", 128'(wr_err), 128'(0));

    // 3: fill with ones
    tick();
    fill_type = 1; fill_start = 1;
    tick();
    fill_start = 0;
    busy_n = 0; done_n = 0; rdy_hi = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (fill_done) done_n++;
      if (!busy) break;
      busy_n++;
      if (wr_ready) rdy_hi++;
    end
    repeat (3) begin
      @(negedge clk);
      if (fill_done) done_n++;
    end
    chk("t3_busy_cycles", 128'(busy_n), 128'(100));
    chk("t3_done_pulses", 128'(done_n), 128'(1));
    chk("t3_ready_during_fill", 128'(rdy_hi), 128'(0));
    chk("t3_all_ones", 128'(data), 128'({100{1'b1}}));

    // 4: fill_start beats a simultaneous write; write is held and lands after the fill
    tick();
    fill_type = 1; fill_start = 1;
    wr_x = 0; wr_y = 0; wr_type = 0; wr_valid = 1;
    tick();
    fill_start = 0;
    wait_n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wr_ready) break;
      tick();
      wait_n++;
    end
    chk("t4_held_cycles", 128'(wait_n), 128'(100));
    chk("t4_busy_low_when_ready", 128'(busy), 128'(0));
    tick();
    wr_valid = 0;
    @(negedge clk);
    chk("t4_bit0", 128'(data[0]), 128'(0));
    chk("t4_rest", 128'(data[99:1]), 128'({99{1'b1}}));

    // 5: reset 40 cycles into a fill
    tick();
    fill_type = 0; fill_start = 1;
    tick();
    fill_start = 0;
    repeat (40) tick();
    #1 rst = 1'b1;
    #1;
    chk("t5_data_zero", 128'(data), 128'(0));
    chk("t5_busy_zero", 128'(busy), 128'(0));
    chk("t5_no_done", 128'(fill_done), 128'(0));
    chk("t5_ready_in_rst", 128'(wr_ready), 128'(0));
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(negedge clk);
    chk("t5_ready_after", 128'(wr_ready), 128'(1));
    done_n = 0;
    repeat (110) begin
      @(negedge clk);
      if (fill_done) done_n++;
    end
    chk("t5_done_count", 128'(done_n), 128'(0));
    chk("t5_data_still_zero", 128'(data), 128'(0));

    // 6: 4x3 grid, 2-bit cells, write (3,2,2'b10) -> data[23:22]
    tick();
    w2_x = 3; w2_y = 2; w2_type = 2'b10; w2_valid = 1;
    tick();
    w2_valid = 0;
    @(negedge clk);
    chk("t6_data2", 128'(data2), 128'(24'h800000));
    chk("t6_err2", 128'(err2), 128'(0));

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
